// File: rtl/bit_serializer_pkg.sv
// Shared types for the byte-to-bit serializer: FSM states, byte width and bit-order helper.
package bit_serializer_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Bit 'idx' of the transmit order, where idx 0 is the first bit on the wire.
    function automatic logic pick_bit(input logic [BYTE_W-1:0] b,
                                      input logic [2:0]        idx,
                                      input logic              msb_first);
        return msb_first ? b[3'd7 - idx] : b[idx];
    endfunction

endpackage

// File: rtl/bit_serializer_byte_fifo.sv
// Byte FIFO, DEPTH a power of two; head is read combinationally, push/pop take effect on the edge.
// Push is ignored when full and pop is ignored when empty, so stored bytes are never overwritten.
module byte_fifo
    import bit_serializer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [BYTE_W-1:0]        push_data,
    input  logic                     pop,
    output logic [BYTE_W-1:0]        pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [BYTE_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              push_ok, pop_ok;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/bit_serializer.sv
// Queues bytes and shifts them out one registered bit per clock; first bit appears two edges after accept.
// in_ready is low only while the FIFO holds DEPTH bytes; back-to-back bytes are emitted with no gap.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int   DEPTH     = 4,
    parameter logic MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ser_bit,
    output logic              ser_valid,
    output logic              busy,
    output logic [7:0]        frame_cnt
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_t            state_q, state_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [BYTE_W-1:0] shreg_q, shreg_d;
    logic              ser_bit_q, ser_bit_d;
    logic              ser_valid_q, ser_valid_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;
    logic              load_next;

    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [BYTE_W-1:0] fifo_data;
    logic [CW-1:0]     fifo_count;

    assign in_ready  = !fifo_full;
    assign fifo_push = in_valid && in_ready;

    byte_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .push_data(in_data),
        .pop      (fifo_pop),
        .pop_data (fifo_data),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // ser_bit_q/ser_valid_q always show bit bit_idx_q of shreg_q while in SHIFT.
    always_comb begin
        state_d     = state_q;
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        frame_cnt_d = frame_cnt_q;
        ser_bit_d   = IDLE_BIT;
        ser_valid_d = 1'b0;
        fifo_pop    = 1'b0;
        load_next   = 1'b0;

        if (state_q == SHIFT) begin
            if (bit_idx_q == 3'd7) begin
                frame_cnt_d = frame_cnt_q + 8'd1;
                load_next   = !fifo_empty;
                if (fifo_empty) begin
                    state_d = IDLE;
                end
            end else begin
                bit_idx_d   = bit_idx_q + 3'd1;
                ser_bit_d   = pick_bit(shreg_q, bit_idx_d, MSB_FIRST);
                ser_valid_d = 1'b1;
            end
        end else begin
            load_next = !fifo_empty;
        end

        if (load_next) begin
            fifo_pop    = 1'b1;
            shreg_d     = fifo_data;
            bit_idx_d   = 3'd0;
            state_d     = SHIFT;
            ser_bit_d   = pick_bit(fifo_data, 3'd0, MSB_FIRST);
            ser_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_idx_q   <= 3'd0;
            shreg_q     <= '0;
            ser_bit_q   <= IDLE_BIT;
            ser_valid_q <= 1'b0;
            frame_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            bit_idx_q   <= bit_idx_d;
            shreg_q     <= shreg_d;
            ser_bit_q   <= ser_bit_d;
            ser_valid_q <= ser_valid_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign ser_bit   = ser_bit_q;
    assign ser_valid = ser_valid_q;
    assign frame_cnt = frame_cnt_q;
    assign busy      = (fifo_count != '0) || (state_q == SHIFT);

endmodule

// File: tb/tb_bit_serializer.sv
// Two serializer builds (MSB-first/idle 0 and LSB-first/idle 1) fed identical byte streams.
module tb_bit_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;

    logic       m_ready, m_bit, m_valid, m_busy;
    logic [7:0] m_cnt;
    logic       l_ready, l_bit, l_valid, l_busy;
    logic [7:0] l_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_frames = 0;

    logic collect_en = 1'b0;
    logic obs_m[$];
    logic obs_l[$];

    always #5 clk = ~clk;

    bit_serializer #(.DEPTH(4), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(m_ready),
        .ser_bit(m_bit), .ser_valid(m_valid), .busy(m_busy), .frame_cnt(m_cnt)
    );

    bit_serializer #(.DEPTH(4), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_l (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(l_ready),
        .ser_bit(l_bit), .ser_valid(l_valid), .busy(l_busy), .frame_cnt(l_cnt)
    );

    always @(negedge clk) begin
        if (collect_en) begin
            if (m_valid) obs_m.push_back(m_bit);
            if (l_valid) obs_l.push_back(l_bit);
        end
    end

    // Rebuild byte j of a captured bit stream from its wire order.
    function automatic logic [7:0] rebuild(input logic q[$], input int j, input logic msb);
        logic [7:0] b;
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (msb) b[7-i] = q[8*j+i];
            else     b[i]   = q[8*j+i];
        end
        return b;
    endfunction

    task automatic push_byte(input logic [7:0] b);
        int w;
        w = 0;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        while (!m_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        n_checks++;
        if (!m_ready) begin
            n_fail++;
            $display("FAIL push_wait: in_ready=%b after %0d cycles, required 1", m_ready, w);
        end
        @(posedge clk);
        exp_frames++;
    endtask

    task automatic idle_inputs;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain(input int limit);
        int w;
        w = 0;
        while ((m_busy || l_busy) && w < limit) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        n_checks++;
        if (m_busy !== 1'b0 || l_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_busy: busy m=%b l=%b, required 0 0", m_busy, l_busy);
        end
    endtask

    task automatic check_streams(input string name, input logic [7:0] sent[$]);
        n_checks++;
        if (obs_m.size() != 8*sent.size() || obs_l.size() != 8*sent.size()) begin
            n_fail++;
            $display("FAIL %s_bitcount: m=%0d l=%0d, required %0d", name, obs_m.size(), obs_l.size(), 8*sent.size());
        end else begin
            for (int j = 0; j < sent.size(); j++) begin
                n_checks++;
                if (rebuild(obs_m, j, 1'b1) !== sent[j] || rebuild(obs_l, j, 1'b0) !== sent[j]) begin
                    n_fail++;
                    $display("FAIL %s_byte%0d: msb=%h lsb=%h, required %h", name, j,
                             rebuild(obs_m, j, 1'b1), rebuild(obs_l, j, 1'b0), sent[j]);
                end
            end
        end
        n_checks++;
        if (m_cnt !== 8'(exp_frames) || l_cnt !== 8'(exp_frames)) begin
            n_fail++;
            $display("FAIL %s_frame_cnt: m=%0d l=%0d, required %0d", name, m_cnt, l_cnt, 8'(exp_frames));
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({m_ready, l_ready, m_valid, l_valid, m_busy, l_busy} !== 6'b110000) begin
            n_fail++;
            $display("FAIL reset_ctrl: rdy=%b%b vld=%b%b busy=%b%b, required rdy=11 vld=00 busy=00",
                     m_ready, l_ready, m_valid, l_valid, m_busy, l_busy);
        end
        n_checks++;
        if (m_bit !== 1'b0 || l_bit !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_idle_bit: m=%b l=%b, required 0 1", m_bit, l_bit);
        end
        n_checks++;
        if (m_cnt !== 8'd0 || l_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_frame_cnt: m=%0d l=%0d, required 0", m_cnt, l_cnt);
        end
        rst = 1'b0;
        exp_frames = 0;
    endtask

    task automatic test_single_byte;
        logic [7:0] b;
        logic       em, el;
        b = 8'h1B;
        push_byte(b);
        idle_inputs;
        n_checks++;
        if (m_valid !== 1'b0 || m_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_latency: valid=%b busy=%b one edge after accept, required 0 1", m_valid, m_busy);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            em = b[7-i];
            el = b[i];
            n_checks++;
            if (m_valid !== 1'b1 || l_valid !== 1'b1 || m_bit !== em || l_bit !== el) begin
                n_fail++;
                $display("FAIL single_bit%0d: vld=%b%b bits m=%b l=%b, required vld=11 m=%b l=%b",
                         i, m_valid, l_valid, m_bit, l_bit, em, el);
            end
        end
        @(negedge clk);
        n_checks++;
        if (m_valid !== 1'b0 || l_valid !== 1'b0 || m_bit !== 1'b0 || l_bit !== 1'b1 || m_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_after: vld=%b%b bits=%b%b busy=%b, required vld=00 bits=01 busy=0",
                     m_valid, l_valid, m_bit, l_bit, m_busy);
        end
        n_checks++;
        if (m_cnt !== 8'd1 || l_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL single_frame_cnt: m=%0d l=%0d, required 1", m_cnt, l_cnt);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] bytes[$];
        int   n_acc, bits, it, first, last, model_cnt;
        logic drove, rdy_prev, saw_full;
        n_acc = 0; bits = 0; it = 0; first = -1; last = -1; saw_full = 1'b0;
        for (int i = 0; i < 6; i++) bytes.push_back(8'($urandom));
        obs_m.delete();
        obs_l.delete();
        collect_en = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = bytes[0];
        drove    = 1'b1;
        rdy_prev = m_ready;
        while (it < 400 && !(n_acc == 6 && bits == 48)) begin
            @(negedge clk);
            it++;
            if (drove && rdy_prev) n_acc++;
            if (m_valid) begin
                bits++;
                if (first < 0) first = it;
                last = it;
            end
            // Occupancy = accepted bytes minus bytes whose first bit has appeared.
            model_cnt = n_acc - (bits + 7) / 8;
            n_checks++;
            if (m_ready !== (model_cnt < 4) || l_ready !== m_ready) begin
                n_fail++;
                $display("FAIL b2b_in_ready: cycle %0d rdy=%b%b, required %b (count %0d)",
                         it, m_ready, l_ready, model_cnt < 4, model_cnt);
            end
            if (!m_ready) saw_full = 1'b1;
            if (n_acc < 6) begin
                in_data  = bytes[n_acc];
                drove    = 1'b1;
                rdy_prev = m_ready;
            end else begin
                in_valid = 1'b0;
                drove    = 1'b0;
            end
        end
        in_valid = 1'b0;
        exp_frames += n_acc;
        drain(100);
        collect_en = 1'b0;
        n_checks++;
        if (saw_full !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_backpressure: in_ready never fell, required a full FIFO");
        end
        n_checks++;
        if (bits != 48 || last - first != 47) begin
            n_fail++;
            $display("FAIL b2b_contiguous: %0d bits over %0d cycles, required 48 over 48", bits, last - first + 1);
        end
        check_streams("b2b", bytes);
    endtask

    task automatic test_reset_mid_byte;
        logic [7:0] q3[$];
        logic [7:0] fresh[$];
        int k, bits, w;
        q3 = '{8'hDB, 8'h11, 8'h22};
        k = 0; bits = 0; w = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = q3[0];
        while (bits < 4 && w < 50) begin
            @(negedge clk);
            w++;
            if (k < 3) k++;
            if (k < 3) in_data = q3[k];
            else       in_valid = 1'b0;
            if (m_valid) bits++;
        end
        n_checks++;
        if (bits != 4 || m_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_setup: bits=%0d busy=%b, required 4 1", bits, m_busy);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({m_valid, l_valid, m_bit, l_bit, m_busy, m_ready} !== 6'b000101 || m_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL midrst_outputs: vld=%b%b bits=%b%b busy=%b rdy=%b cnt=%0d, required vld=00 bits=01 busy=0 rdy=1 cnt=0",
                     m_valid, l_valid, m_bit, l_bit, m_busy, m_ready, m_cnt);
        end
        exp_frames = 0;
        @(negedge clk);
        rst = 1'b0;
        obs_m.delete();
        obs_l.delete();
        collect_en = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        @(negedge clk);
        in_valid = 1'b0;
        exp_frames++;
        n_checks++;
        if (m_valid !== 1'b0 || m_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_first_accept: valid=%b busy=%b, required 0 1", m_valid, m_busy);
        end
        @(negedge clk);
        n_checks++;
        if (m_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_first_bit: valid=%b, required 1", m_valid);
        end
        drain(100);
        collect_en = 1'b0;
        fresh.push_back(8'hA5);
        check_streams("midrst", fresh);
    endtask

    task automatic test_random_gaps;
        logic [7:0] sent[$];
        logic [7:0] b;
        int gap;
        obs_m.delete();
        obs_l.delete();
        collect_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            b = 8'($urandom);
            push_byte(b);
            sent.push_back(b);
            gap = $urandom_range(0, 12);
            if (gap > 3) begin
                idle_inputs;
                repeat (gap - 4) @(negedge clk);
            end
        end
        idle_inputs;
        drain(500);
        collect_en = 1'b0;
        check_streams("gaps", sent);
    endtask

    task automatic test_frame_wrap;
        logic [7:0] sent[$];
        logic [7:0] b;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_frames = 0;
        obs_m.delete();
        obs_l.delete();
        collect_en = 1'b1;
        for (int i = 0; i < 257; i++) begin
            b = 8'($urandom);
            push_byte(b);
            sent.push_back(b);
        end
        idle_inputs;
        drain(5000);
        collect_en = 1'b0;
        n_checks++;
        if (m_cnt !== 8'd1 || l_cnt !== 8'd1 || m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_frame_cnt: m=%0d l=%0d valid=%b, required 1 1 0", m_cnt, l_cnt, m_valid);
        end
        check_streams("wrap", sent);
    endtask

    task automatic test_detector;
        logic [4:0] hist;
        int len, pulses, pos;
        hist = 5'd0; len = 0; pulses = 0; pos = -1;
        obs_m.delete();
        obs_l.delete();
        collect_en = 1'b1;
        push_byte(8'hDB);
        push_byte(8'h00);
        idle_inputs;
        drain(100);
        collect_en = 1'b0;
        // Non-overlapping 11011 Mealy detector over the MSB-first wire stream.
        for (int i = 0; i < obs_m.size(); i++) begin
            hist = {hist[3:0], obs_m[i]};
            len++;
            if (len >= 5 && hist == 5'b11011) begin
                pulses++;
                if (pos < 0) pos = i;
                len = 0;
            end
        end
        n_checks++;
        if (pulses != 1 || pos != 4 || obs_m.size() != 16) begin
            n_fail++;
            $display("FAIL detect_11011: pulses=%0d at bit %0d of %0d, required 1 at bit 4 of 16",
                     pulses, pos, obs_m.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_single_byte;
        test_back_to_back;
        test_reset_mid_byte;
        test_random_gaps;
        test_frame_wrap;
        test_detector;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
